// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and stall sequencing.
// Holds decode for LD_STALL cycles behind a load and inserts bubbles into execute.
module id_ex_hazard_reg #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned LD_STALL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_D,
  input  logic [N-1:0] RegA_D,
  input  logic [N-1:0] RegB_D,
  input  logic [N-1:0] Rd_D,
  input  logic [W-1:0] OpA_D,
  input  logic [W-1:0] OpB_D,
  input  logic [W-1:0] Imm_D,
  input  logic         regw_D,
  input  logic         memtoreg_D,
  input  logic         memw_D,
  input  logic [2:0]   aluctrl_D,
  input  logic         flush_E,
  output logic [N-1:0] RegA_E,
  output logic [N-1:0] RegB_E,
  output logic [N-1:0] Rd_E,
  output logic [W-1:0] OpA_E,
  output logic [W-1:0] OpB_E,
  output logic [W-1:0] Imm_E,
  output logic         regw_E,
  output logic         memtoreg_E,
  output logic         memw_E,
  output logic         valid_E,
  output logic [2:0]   aluctrl_E,
  output logic         stall_FD
);

  localparam logic [1:0] LD_M1 = 2'(LD_STALL - 1);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       hz;
  logic       take;

  // A load in execute whose destination feeds either decode source.
  assign hz = (state == RUN) && valid_E && memtoreg_E && regw_E && valid_D &&
              ((Rd_E == RegA_D) || (Rd_E == RegB_D));

  // Next-state, bubble/load select and fetch stall.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    stall_FD = 1'b0;
    if (flush_E) begin
      state_nx = RUN;
      cnt_nx   = 2'd0;
    end else if (state == STALL) begin
      stall_FD = valid_D;
      cnt_nx   = cnt - 2'd1;
      if (cnt <= 2'd1) begin
        state_nx = RUN;
        cnt_nx   = 2'd0;
      end
    end else if (hz) begin
      stall_FD = 1'b1;
      cnt_nx   = LD_M1;
      state_nx = (LD_M1 != 2'd0) ? STALL : RUN;
    end else begin
      take = 1'b1;
    end
    if (rst) stall_FD = 1'b0;
  end

  // State register; a bubble is an all-zero execute stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= 2'd0;
      RegA_E     <= '0;
      RegB_E     <= '0;
      Rd_E       <= '0;
      OpA_E      <= '0;
      OpB_E      <= '0;
      Imm_E      <= '0;
      regw_E     <= 1'b0;
      memtoreg_E <= 1'b0;
      memw_E     <= 1'b0;
      valid_E    <= 1'b0;
      aluctrl_E  <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take) begin
        RegA_E     <= RegA_D;
        RegB_E     <= RegB_D;
        Rd_E       <= Rd_D;
        OpA_E      <= OpA_D;
        OpB_E      <= OpB_D;
        Imm_E      <= Imm_D;
        regw_E     <= regw_D;
        memtoreg_E <= memtoreg_D;
        memw_E     <= memw_D;
        valid_E    <= valid_D;
        aluctrl_E  <= aluctrl_D;
      end else begin
        RegA_E     <= '0;
        RegB_E     <= '0;
        Rd_E       <= '0;
        OpA_E      <= '0;
        OpB_E      <= '0;
        Imm_E      <= '0;
        regw_E     <= 1'b0;
        memtoreg_E <= 1'b0;
        memw_E     <= 1'b0;
        valid_E    <= 1'b0;
        aluctrl_E  <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: two instances (LD_STALL = 1 and 3) share stimulus,
// each checked by a scoreboard fed from a stall-count reference model.
module tb_id_ex_hazard_reg;

  typedef struct packed {
    logic [3:0]  rega;
    logic [3:0]  regb;
    logic [3:0]  rd;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] imm;
    logic        regw;
    logic        memtoreg;
    logic        memw;
    logic        valid;
    logic [2:0]  alu;
  } e_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic flush = 1'b0;
  e_t   d     = '0;

  e_t         act [2];
  logic [1:0] stall_w;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned LD = (k == 0) ? 1 : 3;
    logic [3:0]  ra, rb, rdo;
    logic [31:0] oa, ob, im;
    logic        rw, mr, mw, v, st;
    logic [2:0]  al;

    id_ex_hazard_reg #(.N(4), .W(32), .LD_STALL(LD)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .valid_D   (d.valid),
      .RegA_D    (d.rega),
      .RegB_D    (d.regb),
      .Rd_D      (d.rd),
      .OpA_D     (d.opa),
      .OpB_D     (d.opb),
      .Imm_D     (d.imm),
      .regw_D    (d.regw),
      .memtoreg_D(d.memtoreg),
      .memw_D    (d.memw),
      .aluctrl_D (d.alu),
      .flush_E   (flush),
      .RegA_E    (ra),
      .RegB_E    (rb),
      .Rd_E      (rdo),
      .OpA_E     (oa),
      .OpB_E     (ob),
      .Imm_E     (im),
      .regw_E    (rw),
      .memtoreg_E(mr),
      .memw_E    (mw),
      .valid_E   (v),
      .aluctrl_E (al),
      .stall_FD  (st)
    );

    assign act[k]     = {ra, rb, rdo, oa, ob, im, rw, mr, mw, v, al};
    assign stall_w[k] = st;
  end

  int checks = 0;
  int errors = 0;

  // Reference: what execute holds, and how many further decode-hold cycles remain.
  e_t m_e    [2];
  int m_left [2];
  e_t q      [2][$];

  function automatic int ld(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic e_t mk(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rd, input logic rw, input logic mr,
                            input logic mw);
    e_t r;
    r.valid    = v;
    r.rega     = ra;
    r.regb     = rb;
    r.rd       = rd;
    r.regw     = rw;
    r.memtoreg = mr;
    r.memw     = mw;
    r.opa      = $urandom;
    r.opb      = $urandom;
    r.imm      = $urandom;
    r.alu      = 3'($urandom_range(0, 7));
    return r;
  endfunction

  // Drive one cycle of decode input; check the stall and predict the next E stage.
  task automatic step(input e_t di, input logic fl, input logic rs);
    logic hz, exp_st;
    @(negedge clk);
    d     = di;
    flush = fl;
    rst   = rs;
    #1;
    for (int k = 0; k < 2; k++) begin
      hz = (m_left[k] == 0) && m_e[k].valid && m_e[k].memtoreg && m_e[k].regw &&
           di.valid && ((m_e[k].rd == di.rega) || (m_e[k].rd == di.regb));
      exp_st = !rs && !fl && di.valid && ((m_left[k] > 0) || hz);
      checks++;
      if (stall_w[k] !== exp_st) begin
        errors++;
        $display("FAIL stall_FD ld=%0d t=%0t got=%b exp=%b", ld(k), $time, stall_w[k], exp_st);
      end
      if (rs || fl) begin
        m_e[k]    = '0;
        m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_e[k]    = '0;
        m_left[k] = m_left[k] - 1;
      end else if (hz) begin
        m_e[k]    = '0;
        m_left[k] = ld(k) - 1;
      end else begin
        m_e[k] = di;
      end
      q[k].push_back(m_e[k]);
    end
  endtask

  // Monitor: every edge presents a new execute stage; compare against the queue.
  initial begin
    e_t exp_e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() > 0) begin
          exp_e = q[k].pop_front();
          checks++;
          if (act[k] !== exp_e) begin
            errors++;
            $display("FAIL e_stage ld=%0d t=%0t got=%h exp=%h", ld(k), $time, act[k], exp_e);
          end
        end
      end
    end
  end

  initial begin
    e_t idle, c;
    for (int k = 0; k < 2; k++) begin
      m_e[k]    = '0;
      m_left[k] = 0;
    end
    idle = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    step(idle, 1'b0, 1'b1);
    step(idle, 1'b1, 1'b1);

    // ALU producer then consumer: no stall
    step(mk(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step(mk(1'b1, 4'd3, 4'd4, 4'd6, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);

    // load Rd=5 then consumer on RegB, held while stalled
    step(mk(1'b1, 4'd1, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    c = mk(1'b1, 4'd8, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0);
    repeat (5) step(c, 1'b0, 1'b0);

    // store whose data comes from the load still stalls
    step(mk(1'b1, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    c = mk(1'b1, 4'd1, 4'd6, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(c, 1'b0, 1'b0);

    // flush on the hazard cycle wins
    step(mk(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    c = mk(1'b1, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(c, 1'b1, 1'b0);
    repeat (2) step(c, 1'b0, 1'b0);

    // reset during the second STALL cycle
    step(mk(1'b1, 4'd0, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    c = mk(1'b1, 4'd2, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0);
    step(c, 1'b0, 1'b0);
    step(c, 1'b0, 1'b0);
    step(c, 1'b0, 1'b1);
    repeat (3) step(c, 1'b0, 1'b0);

    // no stall with valid_D=0, or when the E-stage load does not write
    step(mk(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(1'b0, 4'd7, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step(mk(1'b1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(1'b1, 4'd7, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);

    // random traffic over a small register set to make hazards frequent
    c = idle;
    for (int i = 0; i < 3000; i++) begin
      if (!(stall_w != 2'b00 && $urandom_range(0, 3) != 0)) begin
        c = mk(($urandom_range(0, 19) < 17) ? 1'b1 : 1'b0,
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 4) < 2) ? 1'b1 : 1'b0,
               ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      end
      step(c, ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end
    step(idle, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL drain ld=%0d got=%0d pending exp=0", ld(k), q[k].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

Interface
REQ-001 SHALL have parameter N, default 4, register-ID width.
REQ-002 SHALL have parameter W, default 32, operand/immediate data width.
REQ-003 SHALL have parameter LD_STALL, default 1, bubbles inserted per load-use hazard (legal 1..3).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 valid_D  input  1  decode holds a real instruction.
REQ-007 RegA_D, RegB_D, Rd_D  input  N each  source A, source B and destination IDs in decode.
REQ-008 OpA_D, OpB_D, Imm_D  input  W each  register-file read data and immediate.
REQ-009 regw_D, memtoreg_D, memw_D  input  1 each  register write, load and store controls.
REQ-010 aluctrl_D  input  3  ALU operation.
REQ-011 flush_E  input  1  taken branch resolved in execute; kill younger instructions.
REQ-012 RegA_E, RegB_E, Rd_E  output  N each  registered IDs, feed the forwarding unit.
REQ-013 OpA_E, OpB_E, Imm_E  output  W each  registered data.
REQ-014 regw_E, memtoreg_E, memw_E, valid_E  output  1 each  registered controls.
REQ-015 aluctrl_E  output  3  registered ALU operation.
REQ-016 stall_FD  output  1  combinational; holds fetch PC and IF/ID register when high.

Function
REQ-017 Load-use hazard (hz) SHALL be: state RUN, valid_E, memtoreg_E, regw_E, valid_D, and (Rd_E == RegA_D or Rd_E == RegB_D); register 0 is not special-cased.
REQ-018 FSM SHALL have states RUN and STALL plus a 2-bit counter cnt.
REQ-019 RUN, no flush_E, no hz: every _E output SHALL load its _D input on the edge; latency exactly one cycle.
REQ-020 RUN with hz and no flush_E: stall_FD SHALL be 1 same cycle; next edge SHALL load a bubble into E, set cnt = LD_STALL-1, go to STALL if cnt would be nonzero, else remain RUN.
REQ-021 Bubble SHALL mean valid_E, regw_E, memtoreg_E, memw_E = 0; IDs, data and aluctrl_E = 0.
REQ-022 STALL: stall_FD SHALL be 1; each edge SHALL load a bubble and decrement cnt; on cnt == 0 at the edge SHALL go to RUN, the held decode instruction then loads normally in the following RUN cycle (hz re-evaluated, now false since E holds a bubble).
REQ-023 hz SHALL NOT be evaluated in STALL.
REQ-024 flush_E SHALL have priority over hz and STALL: stall_FD = 0 that cycle, next edge loads a bubble, state returns to RUN, cnt = 0.
REQ-025 Store after load (memw_D with Rd_E matching only as data source) SHALL still stall; no store-data forwarding exception.
REQ-026 Total stall cycles per hazard SHALL equal LD_STALL; decode instruction SHALL enter E exactly LD_STALL+1 cycles after first hz cycle.
REQ-027 stall_FD SHALL be 0 when valid_D = 0.

Reset
REQ-028 rst high at an edge SHALL force state RUN, cnt 0, all _E outputs 0 (bubble); rst overrides flush_E and hz.
REQ-029 While rst is high stall_FD SHALL be 0.
REQ-030 Reset asserted mid-STALL SHALL abort the stall; first post-reset cycle is RUN.

Verification
REQ-031 Back-to-back ALU ops (regw_D=1, memtoreg_D=0), Rd=3 then RegA=3 -> no stall, RegA_E=3 one cycle after entering decode.
REQ-032 LD_STALL=1: load Rd=5 in E, decode RegB=5 -> stall_FD=1 for one cycle, one bubble (valid_E=0), consumer in E on following edge with RegB_E=5.
REQ-033 LD_STALL=3, same hazard -> stall_FD=1 for 3 consecutive cycles, 3 bubbles, then consumer enters E.
REQ-034 Hazard cycle with flush_E=1 -> stall_FD=0, bubble in E next edge, state RUN, no further stall.
REQ-035 rst asserted during second STALL cycle (LD_STALL=3) -> all _E outputs 0 next edge, stall_FD=0, normal loading resumes after rst drops.
REQ-036 Load Rd=7 in E with valid_D=0 or regw_E=0 -> no stall.
